cajero_controlador: RTL and testbench
=====================================

# cajero_controlador

Transaction controller for the ATM datapath: it sequences a card session from card insertion through 4-digit PIN entry, attempt counting and lockout, to one deposit or withdrawal against an internal 64-bit balance register. It consumes the card, keypad and amount signals that the ATM bench drives, and it produces the status and dispense strobes that the bench checks.

## Interface
- `BALANCE_INICIAL`, default 64'd5000: balance loaded on reset.
- `MAX_INTENTOS`, default 3: number of failed PINs that causes lockout.
- `CLK`  in  1: single clock, rising edge.
- `RESET`  in  1: reset, asynchronous, active-low.
- `TARJETA_RECIBIDA`  in  1: card present (level).
- `PIN`  in  16: correct PIN, 4 BCD digits, MSD in [15:12]; sampled at the comparison.
- `DIGITO`  in  4: keypad digit, valid when `DIGITO_STB`=1.
- `DIGITO_STB`  in  1: one-cycle digit strobe.
- `TIPO_TRANS`  in  1: 0 = deposit, 1 = withdrawal; sampled with `MONTO_STB`.
- `MONTO`  in  32: amount, valid when `MONTO_STB`=1.
- `MONTO_STB`  in  1: one-cycle amount strobe.
- `BALANCE`  out  64: current balance.
- `PIN_INCORRECTO`  out  1: one-cycle pulse on each failed PIN.
- `ADVERTENCIA`  out  1: level; high after failure number `MAX_INTENTOS`-1.
- `BLOQUEO`  out  1: level; lockout.
- `BALANCE_ACTUALIZADO`  out  1: one-cycle pulse when `BALANCE` changes.
- `ENTREGAR_DINERO`  out  1: one-cycle pulse on a successful withdrawal.
- `FONDOS_INSUFICIENTES`  out  1: one-cycle pulse on a rejected withdrawal.

## Operation
- States: ESPERA_TARJETA, INGRESO_PIN, VERIFICAR_PIN, ESPERA_MONTO, FIN, BLOQUEADO.
- ESPERA_TARJETA: on `TARJETA_RECIBIDA`=1, go to INGRESO_PIN and clear the digit count and the digit register.
- INGRESO_PIN: on each `DIGITO_STB`, shift `DIGITO` into the 16-bit register at the LSB and increment the count (0..4). When the count reaches 4, go to VERIFICAR_PIN.
- VERIFICAR_PIN, one cycle, compares the register with `PIN`:
  - Match: clear the attempt counter, clear `ADVERTENCIA`, go to ESPERA_MONTO.
  - Mismatch: increment the attempt counter and pulse `PIN_INCORRECTO`.
    - If attempts = `MAX_INTENTOS`-1, set `ADVERTENCIA`.
    - If attempts = `MAX_INTENTOS`, go to BLOQUEADO, set `BLOQUEO`, clear `ADVERTENCIA`.
    - Otherwise, go back to INGRESO_PIN with the digit count cleared.
- ESPERA_MONTO: on `MONTO_STB`, go to FIN with one of these outcomes:
  - Deposit: `BALANCE` += zero-extended `MONTO`, wrapping modulo 2^64; pulse `BALANCE_ACTUALIZADO`.
  - Withdrawal with `MONTO` <= `BALANCE`: subtract; pulse `BALANCE_ACTUALIZADO` and `ENTREGAR_DINERO` together. Equal amounts are allowed and leave the balance at 0.
  - Withdrawal with `MONTO` > `BALANCE`: pulse `FONDOS_INSUFICIENTES`; `BALANCE` is unchanged.
- FIN: wait for `TARJETA_RECIBIDA`=0, then go to ESPERA_TARJETA.
- Card removal (`TARJETA_RECIBIDA`=0) in INGRESO_PIN, VERIFICAR_PIN or ESPERA_MONTO aborts the session: go to ESPERA_TARJETA, with the attempt counter and `ADVERTENCIA` retained.
- BLOQUEADO: exits only on `RESET`. All strobes are ignored there.
- `DIGITO_STB` is ignored outside INGRESO_PIN; `MONTO_STB` is ignored outside ESPERA_MONTO.

## Timing
- Reset values: state = ESPERA_TARJETA; `BALANCE` = `BALANCE_INICIAL`; attempts = 0; digit count = 0; all 1-bit outputs = 0.
- All outputs are registered.
- A digit strobe sampled at edge N is in the register after N. If it is the 4th digit, the state is VERIFICAR_PIN during N..N+1, and the result outputs and the next state update at edge N+1.
- Amount strobe sampled at edge M: `BALANCE` and the pulses update at M+1; pulses fall at M+2.
- A strobe that coincides with card removal is ignored; removal wins.
- Back-to-back `DIGITO_STB` on consecutive cycles is accepted.
- Digit strobes during VERIFICAR_PIN are dropped.
- An asynchronous `RESET` in any state restores all reset values immediately, including the balance.

## Structure
- Package `cajero_pkg` holds:
  - the state enum (3-bit encoding),
  - `LARGO_PIN` = 4,
  - widths `ANCHO_MONTO` = 32 and `ANCHO_BALANCE` = 64.
- Sub-module `captura_pin` contains the digit shift register and the 3-bit count, with `clear` and `done` ports. The FSM, attempt counter and balance datapath stay at top level.

## Test plan
- `PIN`=16'h3473; enter 1,3,7,8 three times -> `PIN_INCORRECTO` pulses 3×; `ADVERTENCIA` high after the 2nd failure; `BLOQUEO`=1 after the 3rd; further digits are ignored until `RESET`.
- Enter 3,4,7,3, then deposit `MONTO`=2000 -> `BALANCE` goes 5000→7000, `BALANCE_ACTUALIZADO` is a single pulse, `ENTREGAR_DINERO`=0.
- Two wrong PINs, then 3,4,7,3, then withdraw 2000 -> attempts clear, `ADVERTENCIA` falls, `BALANCE`=5000, `ENTREGAR_DINERO` and `BALANCE_ACTUALIZADO` pulse together.
- Correct PIN, withdraw 10000 with `BALANCE`=5000 -> `FONDOS_INSUFICIENTES` pulses; `BALANCE` stays 5000; no dispense.
- Edge cases:
  - Withdraw exactly 5000 -> `BALANCE`=0, `ENTREGAR_DINERO` pulses.
  - Remove the card after 2 digits, reinsert -> digit count restarts at 0.
- Deposit 1 with `BALANCE_INICIAL`=2^64-1 -> `BALANCE` wraps to 0; assert `RESET` mid-ESPERA_MONTO -> all outputs and `BALANCE` return to reset values asynchronously.

Source files
------------

// File: rtl/cajero_pkg.sv
// rtl/cajero_pkg.sv - shared states, widths and PIN length for the ATM controller
package cajero_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA = 3'd0,
        INGRESO_PIN    = 3'd1,
        VERIFICAR_PIN  = 3'd2,
        ESPERA_MONTO   = 3'd3,
        FIN            = 3'd4,
        BLOQUEADO      = 3'd5
    } estado_t;

    localparam int LARGO_PIN     = 4;
    localparam int ANCHO_PIN     = 4 * LARGO_PIN;
    localparam int ANCHO_MONTO   = 32;
    localparam int ANCHO_BALANCE = 64;

endpackage

// File: rtl/cajero_controlador_if.sv
// rtl/cajero_controlador_if.sv - card, keypad, amount and status bundle of the ATM controller
interface cajero_controlador_if;
    import cajero_pkg::*;

    logic                     TARJETA_RECIBIDA;
    logic [ANCHO_PIN-1:0]     PIN;
    logic [3:0]               DIGITO;
    logic                     DIGITO_STB;
    logic                     TIPO_TRANS;
    logic [ANCHO_MONTO-1:0]   MONTO;
    logic                     MONTO_STB;
    logic [ANCHO_BALANCE-1:0] BALANCE;
    logic                     PIN_INCORRECTO;
    logic                     ADVERTENCIA;
    logic                     BLOQUEO;
    logic                     BALANCE_ACTUALIZADO;
    logic                     ENTREGAR_DINERO;
    logic                     FONDOS_INSUFICIENTES;

    modport master (
        output TARJETA_RECIBIDA, PIN, DIGITO, DIGITO_STB, TIPO_TRANS, MONTO, MONTO_STB,
        input  BALANCE, PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
               BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES
    );

    modport slave (
        input  TARJETA_RECIBIDA, PIN, DIGITO, DIGITO_STB, TIPO_TRANS, MONTO, MONTO_STB,
        output BALANCE, PIN_INCORRECTO, ADVERTENCIA, BLOQUEO,
               BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES
    );

endinterface

// File: rtl/captura_pin.sv
// rtl/captura_pin.sv - keypad digit shift register with entry count
module captura_pin
    import cajero_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 stb,
    input  logic [3:0]           digito,
    output logic [ANCHO_PIN-1:0] digitos,
    output logic                 done
);

    logic [2:0] cuenta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digitos <= '0;
            cuenta  <= '0;
        end else if (clear) begin
            digitos <= '0;
            cuenta  <= '0;
        end else if (stb && (cuenta < 3'(LARGO_PIN))) begin
            digitos <= {digitos[ANCHO_PIN-5:0], digito};
            cuenta  <= cuenta + 3'd1;
        end
    end

    // Flags the strobe that completes the PIN so the FSM leaves entry on the same edge.
    assign done = stb && (cuenta == 3'(LARGO_PIN - 1));

endmodule

// File: rtl/cajero_controlador.sv
// rtl/cajero_controlador.sv - ATM session FSM: PIN check, attempt lockout, balance update
module cajero_controlador
    import cajero_pkg::*;
#(
    parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL = 64'd5000,
    parameter int                       MAX_INTENTOS    = 3
) (
    input logic                 CLK,
    input logic                 RESET,
    cajero_controlador_if.slave bus
);

    estado_t estado, estado_sig;

    logic [ANCHO_PIN-1:0]     digitos;
    logic                     tarjeta, digito_ok, clear_pin, pin_done, pin_ok;
    logic [7:0]               intentos, intentos_d, intentos_inc;
    logic                     advertencia, advertencia_d, bloqueo, bloqueo_d;
    logic                     pin_inc, pin_inc_d, actualizado, actualizado_d;
    logic                     entregar, entregar_d, fondos_ins, fondos_ins_d;
    logic [ANCHO_BALANCE-1:0] balance, balance_d, monto_ext;
    logic [ANCHO_MONTO-1:0]   monto_q, monto_d;
    logic                     tipo_q, tipo_d, pendiente, pendiente_d;

    assign tarjeta      = bus.TARJETA_RECIBIDA;
    assign digito_ok    = (estado == INGRESO_PIN) && tarjeta && bus.DIGITO_STB;
    assign clear_pin    = (estado == ESPERA_TARJETA) || (estado == VERIFICAR_PIN);
    assign pin_ok       = (digitos == bus.PIN);
    assign intentos_inc = intentos + 8'd1;
    assign monto_ext    = {{(ANCHO_BALANCE - ANCHO_MONTO){1'b0}}, monto_q};

    captura_pin u_captura (
        .clk     (CLK),
        .rst_n   (RESET),
        .clear   (clear_pin),
        .stb     (digito_ok),
        .digito  (bus.DIGITO),
        .digitos (digitos),
        .done    (pin_done)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) estado <= ESPERA_TARJETA;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA_TARJETA: if (tarjeta) estado_sig = INGRESO_PIN;
            INGRESO_PIN: begin
                if (!tarjeta)      estado_sig = ESPERA_TARJETA;
                else if (pin_done) estado_sig = VERIFICAR_PIN;
            end
            VERIFICAR_PIN: begin
                if (!tarjeta)                                   estado_sig = ESPERA_TARJETA;
                else if (pin_ok)                                estado_sig = ESPERA_MONTO;
                else if (intentos_inc == 8'(MAX_INTENTOS))      estado_sig = BLOQUEADO;
                else                                            estado_sig = INGRESO_PIN;
            end
            ESPERA_MONTO: begin
                if (!tarjeta)           estado_sig = ESPERA_TARJETA;
                else if (bus.MONTO_STB) estado_sig = FIN;
            end
            FIN:       if (!tarjeta) estado_sig = ESPERA_TARJETA;
            BLOQUEADO: estado_sig = BLOQUEADO;
            default:   estado_sig = ESPERA_TARJETA;
        endcase
    end

    always_comb begin
        intentos_d    = intentos;
        advertencia_d = advertencia;
        bloqueo_d     = bloqueo;
        pin_inc_d     = 1'b0;
        actualizado_d = 1'b0;
        entregar_d    = 1'b0;
        fondos_ins_d  = 1'b0;
        balance_d     = balance;
        monto_d       = monto_q;
        tipo_d        = tipo_q;
        pendiente_d   = 1'b0;

        if ((estado == VERIFICAR_PIN) && tarjeta) begin
            if (pin_ok) begin
                intentos_d    = '0;
                advertencia_d = 1'b0;
            end else begin
                intentos_d = intentos_inc;
                pin_inc_d  = 1'b1;
                if (intentos_inc == 8'(MAX_INTENTOS)) begin
                    bloqueo_d     = 1'b1;
                    advertencia_d = 1'b0;
                end else if (intentos_inc == 8'(MAX_INTENTOS - 1)) begin
                    advertencia_d = 1'b1;
                end
            end
        end

        // The amount is latched first and applied one cycle later, so results land at M+1.
        if ((estado == ESPERA_MONTO) && tarjeta && bus.MONTO_STB) begin
            pendiente_d = 1'b1;
            monto_d     = bus.MONTO;
            tipo_d      = bus.TIPO_TRANS;
        end

        if (pendiente) begin
            if (!tipo_q) begin
                balance_d     = balance + monto_ext;
                actualizado_d = 1'b1;
            end else if (monto_ext <= balance) begin
                balance_d     = balance - monto_ext;
                actualizado_d = 1'b1;
                entregar_d    = 1'b1;
            end else begin
                fondos_ins_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            intentos    <= '0;
            advertencia <= 1'b0;
            bloqueo     <= 1'b0;
            pin_inc     <= 1'b0;
            actualizado <= 1'b0;
            entregar    <= 1'b0;
            fondos_ins  <= 1'b0;
            balance     <= BALANCE_INICIAL;
            monto_q     <= '0;
            tipo_q      <= 1'b0;
            pendiente   <= 1'b0;
        end else begin
            intentos    <= intentos_d;
            advertencia <= advertencia_d;
            bloqueo     <= bloqueo_d;
            pin_inc     <= pin_inc_d;
            actualizado <= actualizado_d;
            entregar    <= entregar_d;
            fondos_ins  <= fondos_ins_d;
            balance     <= balance_d;
            monto_q     <= monto_d;
            tipo_q      <= tipo_d;
            pendiente   <= pendiente_d;
        end
    end

    assign bus.BALANCE              = balance;
    assign bus.PIN_INCORRECTO       = pin_inc;
    assign bus.ADVERTENCIA          = advertencia;
    assign bus.BLOQUEO              = bloqueo;
    assign bus.BALANCE_ACTUALIZADO  = actualizado;
    assign bus.ENTREGAR_DINERO      = entregar;
    assign bus.FONDOS_INSUFICIENTES = fondos_ins;

endmodule

// File: tb/tb_cajero_controlador.sv
// tb/tb_cajero_controlador.sv - self-checking bench for cajero_controlador
module tb_cajero_controlador;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    longint unsigned m_bal;
    int              m_att;
    bit              m_warn, m_lock;
    localparam int   MAXI = 3;

    cajero_controlador_if bus ();
    cajero_controlador_if bus_w ();

    cajero_controlador dut (.CLK(clk), .RESET(rst_n), .bus(bus));
    cajero_controlador #(.BALANCE_INICIAL(64'hFFFF_FFFF_FFFF_FFFF)) dut_w (
        .CLK(clk), .RESET(rst_n), .bus(bus_w));

    always #5 clk = ~clk;

    task automatic tick; @(posedge clk); #1; endtask

    task automatic model_reset;
        m_bal = 64'd5000; m_att = 0; m_warn = 0; m_lock = 0;
    endtask

    task automatic model_pin(input logic [15:0] entered, input logic [15:0] pin, output bit fail);
        fail = 0;
        if (m_lock) return;
        if (entered == pin) begin
            m_att = 0; m_warn = 0;
        end else begin
            fail = 1; m_att++;
            if (m_att == MAXI) begin m_lock = 1; m_warn = 0; end
            else if (m_att == MAXI - 1) m_warn = 1;
        end
    endtask

    task automatic model_amount(input bit tipo, input logic [31:0] monto, output bit upd, output bit ent, output bit fi);
        longint unsigned m = 64'(monto);
        upd = 0; ent = 0; fi = 0;
        if (!tipo) begin m_bal = m_bal + m; upd = 1; end
        else if (m > m_bal) fi = 1;
        else begin m_bal = m_bal - m; upd = 1; ent = 1; end
    endtask

    function automatic logic [15:0] rand_pin();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic idle;
        bus.TARJETA_RECIBIDA = 0; bus.DIGITO = 0; bus.DIGITO_STB = 0;
        bus.TIPO_TRANS = 0; bus.MONTO = 0; bus.MONTO_STB = 0; bus.PIN = 16'h3473;
        bus_w.TARJETA_RECIBIDA = 0; bus_w.DIGITO = 0; bus_w.DIGITO_STB = 0;
        bus_w.TIPO_TRANS = 0; bus_w.MONTO = 0; bus_w.MONTO_STB = 0; bus_w.PIN = 16'h1234;
    endtask

    task automatic do_reset;
        bus.TARJETA_RECIBIDA = 0; bus_w.TARJETA_RECIBIDA = 0;
        rst_n = 0; #2; rst_n = 1;
        model_reset(); tick();
    endtask

    task automatic insert; bus.TARJETA_RECIBIDA = 1; tick(); endtask
    task automatic remove; bus.TARJETA_RECIBIDA = 0; tick(); endtask

    task automatic digit(input logic [3:0] d);
        bus.DIGITO = d; bus.DIGITO_STB = 1; tick(); bus.DIGITO_STB = 0;
    endtask

    // Leaves the bench just after the edge that publishes the PIN verdict.
    task automatic enter4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) digit(v[15 - 4*i -: 4]);
        tick();
    endtask

    task automatic amount(input bit tipo, input logic [31:0] monto);
        bus.TIPO_TRANS = tipo; bus.MONTO = monto; bus.MONTO_STB = 1; tick(); bus.MONTO_STB = 0;
    endtask

    task automatic test_reset;
        idle(); rst_n = 0; tick(); tick();
        checks++;
        if (bus.BALANCE !== 64'd5000) begin failures++; $display("FAIL reset_balance got=%0d want=5000", bus.BALANCE); end
        checks++;
        if ({bus.PIN_INCORRECTO, bus.ADVERTENCIA, bus.BLOQUEO, bus.BALANCE_ACTUALIZADO,
             bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000", {bus.PIN_INCORRECTO, bus.ADVERTENCIA,
                bus.BLOQUEO, bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES});
        end
        rst_n = 1; model_reset(); tick();
    endtask

    task automatic test_lockout;
        bit f;
        insert();
        for (int k = 1; k <= 3; k++) begin
            enter4(16'h1378); model_pin(16'h1378, 16'h3473, f);
            checks++;
            if (bus.PIN_INCORRECTO !== 1'b1) begin failures++; $display("FAIL lock_pulse%0d got=%b want=1", k, bus.PIN_INCORRECTO); end
            checks++;
            if (bus.ADVERTENCIA !== m_warn) begin failures++; $display("FAIL lock_warn%0d got=%b want=%b", k, bus.ADVERTENCIA, m_warn); end
            checks++;
            if (bus.BLOQUEO !== m_lock) begin failures++; $display("FAIL lock_bloqueo%0d got=%b want=%b", k, bus.BLOQUEO, m_lock); end
            tick();
            checks++;
            if (bus.PIN_INCORRECTO !== 1'b0) begin failures++; $display("FAIL lock_pulse_fall%0d got=%b want=0", k, bus.PIN_INCORRECTO); end
        end
        enter4(16'h3473);
        amount(0, 32'd100); tick(); tick();
        checks++;
        if (bus.PIN_INCORRECTO !== 1'b0 || bus.BLOQUEO !== 1'b1 || bus.BALANCE !== 64'd5000)
            begin failures++; $display("FAIL locked_ignore inc=%b bloq=%b bal=%0d want 0/1/5000",
                bus.PIN_INCORRECTO, bus.BLOQUEO, bus.BALANCE); end
        do_reset();
        checks++;
        if (bus.BLOQUEO !== 1'b0) begin failures++; $display("FAIL lock_reset got=%b want=0", bus.BLOQUEO); end
    endtask

    task automatic test_deposit;
        bit u, e, fi;
        insert(); enter4(16'h3473);
        amount(0, 32'd2000);
        checks++;
        if (bus.BALANCE !== 64'd5000 || bus.BALANCE_ACTUALIZADO !== 1'b0)
            begin failures++; $display("FAIL dep_early bal=%0d upd=%b want 5000/0", bus.BALANCE, bus.BALANCE_ACTUALIZADO); end
        tick(); model_amount(0, 32'd2000, u, e, fi);
        checks++;
        if (bus.BALANCE !== 64'd7000 || bus.BALANCE !== m_bal)
            begin failures++; $display("FAIL dep_balance got=%0d want=7000", bus.BALANCE); end
        checks++;
        if (bus.BALANCE_ACTUALIZADO !== 1'b1 || bus.ENTREGAR_DINERO !== 1'b0)
            begin failures++; $display("FAIL dep_pulses upd=%b ent=%b want 1/0", bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO); end
        tick();
        checks++;
        if (bus.BALANCE_ACTUALIZADO !== 1'b0) begin failures++; $display("FAIL dep_single_pulse got=%b want=0", bus.BALANCE_ACTUALIZADO); end
        remove();
    endtask

    task automatic test_warn_clear;
        bit f, u, e, fi;
        logic [15:0] w;
        insert();
        for (int k = 1; k <= 2; k++) begin
            do w = rand_pin(); while (w == 16'h3473);
            enter4(w); model_pin(w, 16'h3473, f);
            checks++;
            if (bus.PIN_INCORRECTO !== 1'b1 || bus.ADVERTENCIA !== m_warn)
                begin failures++; $display("FAIL warn_fail%0d inc=%b warn=%b want 1/%b", k, bus.PIN_INCORRECTO, bus.ADVERTENCIA, m_warn); end
        end
        enter4(16'h3473); model_pin(16'h3473, 16'h3473, f);
        checks++;
        if (bus.ADVERTENCIA !== 1'b0 || bus.PIN_INCORRECTO !== 1'b0)
            begin failures++; $display("FAIL warn_clear warn=%b inc=%b want 0/0", bus.ADVERTENCIA, bus.PIN_INCORRECTO); end
        amount(1, 32'd2000); tick(); model_amount(1, 32'd2000, u, e, fi);
        checks++;
        if (bus.BALANCE !== 64'd5000 || bus.ENTREGAR_DINERO !== 1'b1 || bus.BALANCE_ACTUALIZADO !== 1'b1)
            begin failures++; $display("FAIL withdraw bal=%0d ent=%b upd=%b want 5000/1/1",
                bus.BALANCE, bus.ENTREGAR_DINERO, bus.BALANCE_ACTUALIZADO); end
        tick(); remove();
    endtask

    task automatic test_insufficient;
        insert(); enter4(16'h3473);
        amount(1, 32'd10000); tick();
        checks++;
        if (bus.FONDOS_INSUFICIENTES !== 1'b1 || bus.BALANCE !== 64'd5000 ||
            bus.ENTREGAR_DINERO !== 1'b0 || bus.BALANCE_ACTUALIZADO !== 1'b0)
            begin failures++; $display("FAIL insufficient fi=%b bal=%0d ent=%b upd=%b want 1/5000/0/0",
                bus.FONDOS_INSUFICIENTES, bus.BALANCE, bus.ENTREGAR_DINERO, bus.BALANCE_ACTUALIZADO); end
        tick();
        checks++;
        if (bus.FONDOS_INSUFICIENTES !== 1'b0) begin failures++; $display("FAIL insufficient_fall got=%b want=0", bus.FONDOS_INSUFICIENTES); end
        remove();
    endtask

    task automatic test_exact;
        insert(); enter4(16'h3473);
        amount(1, 32'd5000); tick();
        checks++;
        if (bus.BALANCE !== 64'd0 || bus.ENTREGAR_DINERO !== 1'b1)
            begin failures++; $display("FAIL exact bal=%0d ent=%b want 0/1", bus.BALANCE, bus.ENTREGAR_DINERO); end
        tick(); remove(); do_reset();
    endtask

    task automatic test_abort;
        bit f, u, e, fi;
        insert(); digit(4'd3); digit(4'd4); remove(); insert();
        enter4(16'h3473); model_pin(16'h3473, 16'h3473, f);
        checks++;
        if (bus.PIN_INCORRECTO !== 1'b0) begin failures++; $display("FAIL abort_restart inc=%b want=0", bus.PIN_INCORRECTO); end
        amount(0, 32'd1); tick(); model_amount(0, 32'd1, u, e, fi);
        checks++;
        if (bus.BALANCE !== m_bal) begin failures++; $display("FAIL abort_session bal=%0d want=%0d", bus.BALANCE, m_bal); end
        tick(); remove();
        insert(); enter4(16'h1111); model_pin(16'h1111, 16'h3473, f); remove();
        insert(); enter4(16'h2222); model_pin(16'h2222, 16'h3473, f);
        checks++;
        if (bus.ADVERTENCIA !== 1'b1 || m_warn !== 1'b1) begin failures++; $display("FAIL abort_keeps_attempts warn=%b want=1", bus.ADVERTENCIA); end
        enter4(16'h3473); model_pin(16'h3473, 16'h3473, f); remove();
    endtask

    task automatic test_random;
        bit f, u, e, fi, tipo;
        logic [15:0] pin, v;
        logic [31:0] monto;
        for (int s = 0; s < 30; s++) begin
            pin = rand_pin(); bus.PIN = pin;
            insert();
            for (int a = 0; a < 4; a++) begin
                v = ($urandom_range(0, 1) == 0) ? pin : rand_pin();
                enter4(v); model_pin(v, pin, f);
                checks++;
                if (bus.PIN_INCORRECTO !== f || bus.ADVERTENCIA !== m_warn || bus.BLOQUEO !== m_lock)
                    begin failures++; $display("FAIL rnd_pin s=%0d inc=%b warn=%b bloq=%b want %b/%b/%b", s,
                        bus.PIN_INCORRECTO, bus.ADVERTENCIA, bus.BLOQUEO, f, m_warn, m_lock); end
                if (!f || m_lock) break;
            end
            if (m_lock) begin
                do_reset();
                continue;
            end
            if (!f) begin
                tipo = 1'($urandom_range(0, 1));
                monto = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 9000));
                if (tipo && $urandom_range(0, 5) == 0 && m_bal < 64'h1_0000_0000) monto = 32'(m_bal);
                amount(tipo, monto); tick(); model_amount(tipo, monto, u, e, fi);
                checks++;
                if (bus.BALANCE !== m_bal || bus.BALANCE_ACTUALIZADO !== u ||
                    bus.ENTREGAR_DINERO !== e || bus.FONDOS_INSUFICIENTES !== fi)
                    begin failures++; $display("FAIL rnd_amt s=%0d bal=%0d upd=%b ent=%b fi=%b want %0d/%b/%b/%b", s,
                        bus.BALANCE, bus.BALANCE_ACTUALIZADO, bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES, m_bal, u, e, fi); end
                tick();
            end
            remove();
        end
    endtask

    task automatic test_wrap;
        longint unsigned w = 64'hFFFF_FFFF_FFFF_FFFF;
        logic [15:0] p;
        p = bus_w.PIN;
        for (int r = 0; r < 2; r++) begin
            bus_w.TARJETA_RECIBIDA = 1; tick();
            for (int i = 0; i < 4; i++) begin
                bus_w.DIGITO = p[15 - 4*i -: 4]; bus_w.DIGITO_STB = 1; tick(); bus_w.DIGITO_STB = 0;
            end
            tick();
            if (r == 0) begin
                bus_w.TIPO_TRANS = 0; bus_w.MONTO = 32'd1; bus_w.MONTO_STB = 1; tick(); bus_w.MONTO_STB = 0; tick();
                w = w + 64'd1;
                checks++;
                if (bus_w.BALANCE !== w || bus_w.BALANCE_ACTUALIZADO !== 1'b1)
                    begin failures++; $display("FAIL wrap bal=%0d upd=%b want %0d/1", bus_w.BALANCE, bus_w.BALANCE_ACTUALIZADO, w); end
                tick(); bus_w.TARJETA_RECIBIDA = 0; tick();
            end
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (bus_w.BALANCE !== 64'hFFFF_FFFF_FFFF_FFFF || bus.BALANCE !== 64'd5000)
            begin failures++; $display("FAIL async_reset_balance w=%0h main=%0d want ffffffffffffffff/5000", bus_w.BALANCE, bus.BALANCE); end
        checks++;
        if ({bus_w.PIN_INCORRECTO, bus_w.ADVERTENCIA, bus_w.BLOQUEO, bus_w.BALANCE_ACTUALIZADO,
             bus_w.ENTREGAR_DINERO, bus_w.FONDOS_INSUFICIENTES} !== 6'b0)
            begin failures++; $display("FAIL async_reset_flags got=%b want=000000", {bus_w.PIN_INCORRECTO,
                bus_w.ADVERTENCIA, bus_w.BLOQUEO, bus_w.BALANCE_ACTUALIZADO, bus_w.ENTREGAR_DINERO, bus_w.FONDOS_INSUFICIENTES}); end
        bus_w.TARJETA_RECIBIDA = 0; rst_n = 1; model_reset(); tick();
    endtask

    initial begin
        test_reset();
        test_lockout();
        test_deposit();
        test_warn_clear();
        test_insufficient();
        test_exact();
        test_abort();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
